// File: rtl/udc_host_sequencer_if.sv
// udc_host_sequencer_if
// Bundles the host command handshake and the counter-chip bus of the
// udc_host_sequencer into one connection.
//
// Signals:
//   cmd_valid_i, cmd_ready_o          host command handshake
//   plr_i, ulr_i, llr_i, ccr_i        register values supplied with a command
//   ncs_o, nwr_o, nrd_o               active-low chip-select and strobes
//   a1_o, a0_o                        register address (00 PLR .. 11 CCR)
//   dout_o, dout_oe_o, din_i          data bus out, output enable, readback in
//   start_o, ec_i, err_i              counter start pulse and status inputs
//   busy_o, done_o, fault_o           sequence status and completion code
//
// Modports:
//   master  the sequencer side (drives the *_o signals)
//   slave   the host/counter side (drives the *_i signals)

interface udc_host_sequencer_if;

    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] plr_i;
    logic [7:0] ulr_i;
    logic [7:0] llr_i;
    logic [7:0] ccr_i;
    logic       ncs_o;
    logic       nwr_o;
    logic       nrd_o;
    logic       a1_o;
    logic       a0_o;
    logic [7:0] dout_o;
    logic       dout_oe_o;
    logic [7:0] din_i;
    logic       start_o;
    logic       ec_i;
    logic       err_i;
    logic       busy_o;
    logic       done_o;
    logic [1:0] fault_o;

    modport master (
        input  cmd_valid_i, plr_i, ulr_i, llr_i, ccr_i, din_i, ec_i, err_i,
        output cmd_ready_o, ncs_o, nwr_o, nrd_o, a1_o, a0_o, dout_o,
               dout_oe_o, start_o, busy_o, done_o, fault_o
    );

    modport slave (
        output cmd_valid_i, plr_i, ulr_i, llr_i, ccr_i, din_i, ec_i, err_i,
        input  cmd_ready_o, ncs_o, nwr_o, nrd_o, a1_o, a0_o, dout_o,
               dout_oe_o, start_o, busy_o, done_o, fault_o
    );

endinterface

// File: rtl/udc_host_sequencer.sv
// udc_host_sequencer
// Accepts one command from a host, programs the four registers of an
// up/down counter chip (PLR, ULR, LLR, CCR) over its strobed bus, checks the
// chip's error flag, pulses start and then waits for end-of-count or a
// timeout. Every sequence ends with a one-cycle done pulse and a fault code:
//   0 end-of-count seen, 1 rejected (CCR zero or chip error),
//   2 RUN timeout, 3 readback mismatch.
//
// Ports:
//   clock_i   single clock, rising edge
//   reset_i   synchronous, active-high reset
//   bus       udc_host_sequencer_if.master (handshake, counter bus, status)
//
// Parameter:
//   RUN_TIMEOUT  cycles after the START cycle at which RUN gives up
//
// Configuration macro:
//   UDC_SEQ_READBACK_EN  when defined, each register write is followed by a
//                        two-cycle read of the same register that must return
//                        the value just written.

module udc_host_sequencer #(
    parameter int RUN_TIMEOUT = 4095
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    udc_host_sequencer_if.master   bus
);

    localparam int          CNT_W         = (RUN_TIMEOUT < 2) ? 1 : $clog2(RUN_TIMEOUT + 1);
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(RUN_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
`ifdef UDC_SEQ_READBACK_EN
        RD_WAIT,
        RD_CHECK,
`endif
        ERR_CHK,
        START,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0][7:0]  field_q;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;
    logic [1:0]       fault_q;
    logic [1:0]       fault_d;
    logic             load_fields;
    logic             timeout_hit;

    logic             ncs;
    logic             nwr;
    logic             nrd;
    logic             dout_oe;
    logic [7:0]       dout;
    logic [1:0]       addr;
    logic             start;
    logic             done;
    logic [1:0]       fault;

    // run_cnt_q holds the number of cycles elapsed since the START cycle, so
    // the timeout fires on the RUN cycle whose successor would be cycle
    // RUN_TIMEOUT after START; DONE then lands exactly RUN_TIMEOUT cycles
    // after the start pulse.
    assign timeout_hit = (32'(run_cnt_q) + 32'd1) >= TIMEOUT_LIMIT;

`ifndef UDC_SEQ_READBACK_EN
    // Without readback the data bus input is not consumed.
    logic unused_din;
    assign unused_din = ^bus.din_i;
`endif

    // State register plus the captured command fields. Fields are loaded
    // only on accept so the bus sees stable data for the whole sequence.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            run_cnt_q <= '0;
            fault_q   <= 2'd0;
            field_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_cnt_q <= run_cnt_d;
            fault_q   <= fault_d;
            if (load_fields) begin
                field_q <= {bus.ccr_i, bus.llr_i, bus.ulr_i, bus.plr_i};
            end
        end
    end

    // Next-state logic. The register index walks 0..3; after the last
    // register the chip error flag is checked before the counter is started.
    // In RUN, end-of-count is tested before the timeout so it wins a tie.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_cnt_d   = run_cnt_q;
        fault_d     = fault_q;
        load_fields = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    load_fields = 1'b1;
                    idx_d       = 2'd0;
                    run_cnt_d   = '0;
                    if (bus.ccr_i == 8'd0) begin
                        fault_d = 2'd1;
                        state_d = DONE;
                    end else begin
                        state_d = WR_SETUP;
                    end
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
`ifdef UDC_SEQ_READBACK_EN
            WR_HOLD:   state_d = RD_WAIT;
            RD_WAIT:   state_d = RD_CHECK;
            RD_CHECK: begin
                if (bus.din_i != field_q[idx_q]) begin
                    fault_d = 2'd3;
                    state_d = DONE;
                end else if (idx_q == 2'd3) begin
                    state_d = ERR_CHK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = WR_SETUP;
                end
            end
`else
            WR_HOLD: begin
                if (idx_q == 2'd3) begin
                    state_d = ERR_CHK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = WR_SETUP;
                end
            end
`endif
            ERR_CHK: begin
                if (bus.err_i) begin
                    fault_d = 2'd1;
                    state_d = DONE;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                run_cnt_d = CNT_W'(1);
                state_d   = RUN;
            end
            RUN: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                if (bus.ec_i) begin
                    fault_d = 2'd0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    fault_d = 2'd2;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state. Chip-select stays low from the
    // first write through RUN because the counter drops its programming as
    // soon as it is deselected. Address and data are only presented while
    // the bus is actually addressing a register.
    always_comb begin
        ncs     = 1'b1;
        nwr     = 1'b1;
        nrd     = 1'b1;
        dout_oe = 1'b0;
        dout    = 8'd0;
        addr    = 2'd0;
        start   = 1'b0;
        done    = 1'b0;
        fault   = 2'd0;

        case (state_q)
            WR_SETUP, WR_HOLD: begin
                ncs     = 1'b0;
                addr    = idx_q;
                dout    = field_q[idx_q];
                dout_oe = 1'b1;
            end
            WR_STROBE: begin
                ncs     = 1'b0;
                nwr     = 1'b0;
                addr    = idx_q;
                dout    = field_q[idx_q];
                dout_oe = 1'b1;
            end
`ifdef UDC_SEQ_READBACK_EN
            RD_WAIT, RD_CHECK: begin
                ncs  = 1'b0;
                nrd  = 1'b0;
                addr = idx_q;
            end
`endif
            ERR_CHK, RUN: begin
                ncs = 1'b0;
            end
            START: begin
                ncs   = 1'b0;
                start = 1'b1;
            end
            DONE: begin
                done  = 1'b1;
                fault = fault_q;
            end
            default: begin
                ncs = 1'b1;
            end
        endcase
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.ncs_o       = ncs;
    assign bus.nwr_o       = nwr;
    assign bus.nrd_o       = nrd;
    assign bus.a1_o        = addr[1];
    assign bus.a0_o        = addr[0];
    assign bus.dout_o      = dout;
    assign bus.dout_oe_o   = dout_oe;
    assign bus.start_o     = start;
    assign bus.done_o      = done;
    assign bus.fault_o     = fault;

endmodule

// File: tb/tb_udc_host_sequencer.sv
// tb_udc_host_sequencer
// Drives the sequencer with directed and randomized commands. For every
// command the bench writes out, cycle by cycle, what the host and counter
// pins must look like, then replays that list against the DUT.
// A second instance with the default RUN_TIMEOUT covers a long RUN phase.

module tb_udc_host_sequencer;

    localparam int T_SHORT = 15;
    localparam int T_LONG  = 4095;
`ifdef UDC_SEQ_READBACK_EN
    localparam int EXP_LONG_DONE = 74;
`else
    localparam int EXP_LONG_DONE = 66;
`endif

    typedef struct {
        logic       rst;
        logic       valid;
        logic       ec;
        logic       err;
        logic [7:0] plr;
        logic [7:0] ulr;
        logic [7:0] llr;
        logic [7:0] ccr;
        logic [7:0] din;
        logic       ready;
        logic       busy;
        logic       ncs;
        logic       nwr;
        logic       nrd;
        logic       oe;
        logic       start;
        logic       done;
        logic       bus_chk;
        logic [1:0] addr;
        logic [1:0] fault;
        logic [7:0] dout;
    } cyc_t;

    logic clock;
    logic reset;

    udc_host_sequencer_if ifa ();
    udc_host_sequencer_if ifb ();

    udc_host_sequencer #(.RUN_TIMEOUT(T_SHORT)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (ifa.master)
    );

    udc_host_sequencer #(.RUN_TIMEOUT(T_LONG)) dut_long (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (ifb.master)
    );

    cyc_t       sched[$];
    logic [9:0] wr_log[$];
    int         total;
    int         passed;
    int         cyc;
    bit         sel_long;
    int         acc_cyc;
    int         start_cyc;
    int         done_cyc;
    int         n_start;
    int         n_done;
    logic [1:0] last_fault;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison; every check in the bench goes through here.
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // A cycle in which the sequencer is idle and ready; inputs carry noise.
    function automatic cyc_t idle_rec();
        cyc_t r;
        r.rst     = 1'b0;
        r.valid   = 1'b0;
        r.ec      = 1'($urandom);
        r.err     = 1'($urandom);
        r.plr     = 8'($urandom);
        r.ulr     = 8'($urandom);
        r.llr     = 8'($urandom);
        r.ccr     = 8'($urandom);
        r.din     = 8'($urandom);
        r.ready   = 1'b1;
        r.busy    = 1'b0;
        r.ncs     = 1'b1;
        r.nwr     = 1'b1;
        r.nrd     = 1'b1;
        r.oe      = 1'b0;
        r.start   = 1'b0;
        r.done    = 1'b0;
        r.bus_chk = 1'b0;
        r.addr    = 2'd0;
        r.fault   = 2'd0;
        r.dout    = 8'd0;
        return r;
    endfunction

    // A cycle inside a sequence with the chip selected; a stray command
    // request must be ignored.
    function automatic cyc_t busy_rec();
        cyc_t r;
        r       = idle_rec();
        r.valid = 1'($urandom);
        r.ready = 1'b0;
        r.busy  = 1'b1;
        r.ncs   = 1'b0;
        return r;
    endfunction

    function automatic cyc_t done_rec(input logic [1:0] code);
        cyc_t r;
        r       = busy_rec();
        r.ncs   = 1'b1;
        r.done  = 1'b1;
        r.fault = code;
        return r;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sched.push_back(idle_rec());
    endtask

    // Expected pin trace of one command. ec_at is the RUN cycle (1-based)
    // carrying end-of-count, 0 for never; bad_rb is the register whose
    // readback returns wrong data (-1 none); rst_at is the trace position at
    // which reset is asserted (-1 none), after which the trace is cut.
    task automatic push_txn(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                            input logic [7:0] c, input logic err, input int ec_at,
                            input int bad_rb, input int tmo, input int rst_at);
        cyc_t       t[$];
        cyc_t       r;
        logic [7:0] f[4];
        int         runs;
        logic [1:0] code;
        bit         aborted;
        f[0] = p;
        f[1] = u;
        f[2] = l;
        f[3] = c;
        aborted = 1'b0;
        r = idle_rec();
        r.valid = 1'b1;
        r.plr = p;
        r.ulr = u;
        r.llr = l;
        r.ccr = c;
        t.push_back(r);
        if (c == 8'd0) begin
            t.push_back(done_rec(2'd1));
        end else begin
            for (int w = 0; w < 4 && !aborted; w++) begin
                for (int ph = 0; ph < 3; ph++) begin
                    r = busy_rec();
                    r.addr    = 2'(w);
                    r.dout    = f[w];
                    r.oe      = 1'b1;
                    r.bus_chk = 1'b1;
                    r.nwr     = (ph == 1) ? 1'b0 : 1'b1;
                    t.push_back(r);
                end
`ifdef UDC_SEQ_READBACK_EN
                r = busy_rec();
                r.addr    = 2'(w);
                r.nrd     = 1'b0;
                r.bus_chk = 1'b1;
                t.push_back(r);
                r = busy_rec();
                r.addr    = 2'(w);
                r.nrd     = 1'b0;
                r.bus_chk = 1'b1;
                if (w == bad_rb) begin
                    r.din   = (f[w] == 8'd0) ? 8'hFF : 8'h00;
                    aborted = 1'b1;
                end else begin
                    r.din = f[w];
                end
                t.push_back(r);
`endif
            end
            if (aborted) begin
                t.push_back(done_rec(2'd3));
            end else begin
                r = busy_rec();
                r.err = err;
                t.push_back(r);
                if (err) begin
                    t.push_back(done_rec(2'd1));
                end else begin
                    r = busy_rec();
                    r.start = 1'b1;
                    t.push_back(r);
                    // DONE falls RUN_TIMEOUT cycles after START unless
                    // end-of-count arrives first (or on that same last cycle).
                    if (ec_at > 0 && ec_at <= tmo - 1) begin
                        runs = ec_at;
                        code = 2'd0;
                    end else begin
                        runs = tmo - 1;
                        code = 2'd2;
                    end
                    for (int j = 1; j <= runs; j++) begin
                        r = busy_rec();
                        r.ec = (code == 2'd0 && j == ec_at) ? 1'b1 : 1'b0;
                        t.push_back(r);
                    end
                    t.push_back(done_rec(code));
                end
            end
        end
        foreach (t[i]) begin
            r = t[i];
            if (i == rst_at) r.rst = 1'b1;
            sched.push_back(r);
            if (i == rst_at) break;
        end
    endtask

    task automatic applyStimulus(input cyc_t r);
        reset = r.rst;
        if (sel_long) begin
            ifb.cmd_valid_i = r.valid;
            ifb.plr_i       = r.plr;
            ifb.ulr_i       = r.ulr;
            ifb.llr_i       = r.llr;
            ifb.ccr_i       = r.ccr;
            ifb.din_i       = r.din;
            ifb.ec_i        = r.ec;
            ifb.err_i       = r.err;
            ifa.cmd_valid_i = 1'b0;
        end else begin
            ifa.cmd_valid_i = r.valid;
            ifa.plr_i       = r.plr;
            ifa.ulr_i       = r.ulr;
            ifa.llr_i       = r.llr;
            ifa.ccr_i       = r.ccr;
            ifa.din_i       = r.din;
            ifa.ec_i        = r.ec;
            ifa.err_i       = r.err;
            ifb.cmd_valid_i = 1'b0;
        end
    endtask

    // Compares the selected DUT's pins with the expected cycle and records
    // when accept, start and done were actually seen.
    task automatic checkOutput(input cyc_t r);
        logic       a_ready, a_busy, a_ncs, a_nwr, a_nrd, a_oe, a_start, a_done;
        logic [1:0] a_addr, a_fault;
        logic [7:0] a_dout;
        if (sel_long) begin
            a_ready = ifb.cmd_ready_o; a_busy = ifb.busy_o; a_ncs = ifb.ncs_o;
            a_nwr = ifb.nwr_o; a_nrd = ifb.nrd_o; a_oe = ifb.dout_oe_o;
            a_start = ifb.start_o; a_done = ifb.done_o; a_addr = {ifb.a1_o, ifb.a0_o};
            a_fault = ifb.fault_o; a_dout = ifb.dout_o;
        end else begin
            a_ready = ifa.cmd_ready_o; a_busy = ifa.busy_o; a_ncs = ifa.ncs_o;
            a_nwr = ifa.nwr_o; a_nrd = ifa.nrd_o; a_oe = ifa.dout_oe_o;
            a_start = ifa.start_o; a_done = ifa.done_o; a_addr = {ifa.a1_o, ifa.a0_o};
            a_fault = ifa.fault_o; a_dout = ifa.dout_o;
        end
        chk("cmd_ready_o", 32'(a_ready), 32'(r.ready));
        chk("busy_o", 32'(a_busy), 32'(r.busy));
        chk("ncs_o", 32'(a_ncs), 32'(r.ncs));
        chk("nwr_o", 32'(a_nwr), 32'(r.nwr));
        chk("nrd_o", 32'(a_nrd), 32'(r.nrd));
        chk("dout_oe_o", 32'(a_oe), 32'(r.oe));
        chk("start_o", 32'(a_start), 32'(r.start));
        chk("done_o", 32'(a_done), 32'(r.done));
        if (r.bus_chk) chk("address", 32'(a_addr), 32'(r.addr));
        if (r.oe) chk("dout_o", 32'(a_dout), 32'(r.dout));
        if (r.done) chk("fault_o", 32'(a_fault), 32'(r.fault));
        if (r.valid && a_ready && !r.rst) acc_cyc = cyc;
        if (a_start) begin
            start_cyc = cyc;
            n_start++;
        end
        if (a_done) begin
            done_cyc   = cyc;
            last_fault = a_fault;
            n_done++;
        end
        if (!a_nwr) wr_log.push_back({a_addr, a_dout});
    endtask

    task automatic run_sched();
        cyc_t r;
        while (sched.size() > 0) begin
            r = sched.pop_front();
            @(posedge clock);
            #1;
            applyStimulus(r);
            @(negedge clock);
            checkOutput(r);
            cyc++;
        end
    endtask

    task automatic clear_obs();
        acc_cyc    = -1000;
        start_cyc  = -1000;
        done_cyc   = -1000;
        n_start    = 0;
        n_done     = 0;
        last_fault = 2'd0;
        wr_log.delete();
    endtask

    task automatic zero_inputs();
        ifa.cmd_valid_i = 1'b0; ifa.plr_i = 8'd0; ifa.ulr_i = 8'd0; ifa.llr_i = 8'd0;
        ifa.ccr_i = 8'd0; ifa.din_i = 8'd0; ifa.ec_i = 1'b0; ifa.err_i = 1'b0;
        ifb.cmd_valid_i = 1'b0; ifb.plr_i = 8'd0; ifb.ulr_i = 8'd0; ifb.llr_i = 8'd0;
        ifb.ccr_i = 8'd0; ifb.din_i = 8'd0; ifb.ec_i = 1'b0; ifb.err_i = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_wr [4];
        logic [7:0] rp, ru, rl, rc;
        int         rb;
        int         ra;
        exp_wr[0] = {2'd0, 8'd10};
        exp_wr[1] = {2'd1, 8'd20};
        exp_wr[2] = {2'd2, 8'd5};
        exp_wr[3] = {2'd3, 8'd2};
        total    = 0;
        passed   = 0;
        cyc      = 0;
        sel_long = 1'b0;
        reset    = 1'b1;
        zero_inputs();
        clear_obs();
        repeat (3) @(posedge clock);
        @(negedge clock);

        // Reset state, literal values.
        chk("reset cmd_ready_o", 32'(ifa.cmd_ready_o), 32'd1);
        chk("reset busy_o", 32'(ifa.busy_o), 32'd0);
        chk("reset ncs_o", 32'(ifa.ncs_o), 32'd1);
        chk("reset nwr_o", 32'(ifa.nwr_o), 32'd1);
        chk("reset nrd_o", 32'(ifa.nrd_o), 32'd1);
        chk("reset dout_oe_o", 32'(ifa.dout_oe_o), 32'd0);
        chk("reset start_o", 32'(ifa.start_o), 32'd0);
        chk("reset done_o", 32'(ifa.done_o), 32'd0);
        chk("reset fault_o", 32'(ifa.fault_o), 32'd0);
        chk("reset dout_o", 32'(ifa.dout_o), 32'd0);
        chk("reset address", 32'({ifa.a1_o, ifa.a0_o}), 32'd0);

        // Long-timeout instance: program 10/20/5/2, end-of-count after 50 RUN cycles.
        sel_long = 1'b1;
        clear_obs();
        push_idle(1);
        push_txn(8'd10, 8'd20, 8'd5, 8'd2, 1'b0, 51, -1, T_LONG, -1);
        push_idle(2);
        run_sched();
        chk("write count", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size()) chk("write addr/data", 32'(wr_log[i]), 32'(exp_wr[i]));
        end
        chk("start pulses", 32'(n_start), 32'd1);
        chk("done pulses", 32'(n_done), 32'd1);
        chk("accept to done", 32'(done_cyc - acc_cyc), 32'(EXP_LONG_DONE));
        chk("ec fault code", 32'(last_fault), 32'd0);
        sel_long = 1'b0;

        // CCR zero: immediate reject, no writes.
        clear_obs();
        push_idle(1);
        push_txn(8'd7, 8'd8, 8'd9, 8'd0, 1'b0, 0, -1, T_SHORT, -1);
        push_idle(1);
        run_sched();
        chk("ccr0 write count", 32'(wr_log.size()), 32'd0);
        chk("ccr0 accept to done", 32'(done_cyc - acc_cyc), 32'd1);
        chk("ccr0 fault code", 32'(last_fault), 32'd1);

        // Chip error during the check cycle.
        clear_obs();
        push_txn(8'd30, 8'd20, 8'd5, 8'd3, 1'b1, 3, -1, T_SHORT, -1);
        push_idle(1);
        run_sched();
        chk("err start pulses", 32'(n_start), 32'd0);
        chk("err done pulses", 32'(n_done), 32'd1);
        chk("err fault code", 32'(last_fault), 32'd1);

        // RUN timeout, and end-of-count on the timeout cycle itself.
        clear_obs();
        push_txn(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 0, -1, T_SHORT, -1);
        run_sched();
        chk("timeout start to done", 32'(done_cyc - start_cyc), 32'd15);
        chk("timeout fault code", 32'(last_fault), 32'd2);
        clear_obs();
        push_txn(8'd9, 8'd8, 8'd7, 8'd6, 1'b0, 14, -1, T_SHORT, -1);
        run_sched();
        chk("tie start to done", 32'(done_cyc - start_cyc), 32'd15);
        chk("tie fault code", 32'(last_fault), 32'd0);

        // Reset during the ULR write strobe: no done pulse afterwards.
        clear_obs();
        push_idle(1);
        push_txn(8'd10, 8'd20, 8'd5, 8'd2, 1'b0, 5, -1, T_SHORT, 5);
        push_idle(3);
        run_sched();
        chk("aborted done pulses", 32'(n_done), 32'd0);

`ifdef UDC_SEQ_READBACK_EN
        // ULR readback returns zero.
        clear_obs();
        push_txn(8'd10, 8'd20, 8'd5, 8'd2, 1'b0, 5, 1, T_SHORT, -1);
        push_idle(1);
        run_sched();
        chk("readback start pulses", 32'(n_start), 32'd0);
        chk("readback fault code", 32'(last_fault), 32'd3);
`endif

        // Randomized commands, including back-to-back accepts.
        for (int n = 0; n < 40; n++) begin
            rp = 8'($urandom);
            ru = 8'($urandom);
            rl = 8'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 12)) : -1;
            push_txn(rp, ru, rl, rc, 1'($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 18)), rb, T_SHORT, ra);
            push_idle(int'($urandom_range(0, 2)));
        end
        run_sched();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/udc_host_sequencer.md
UDC_HOST_SEQUENCER -- requirements
Module: udc_host_sequencer

Interface
REQ-001 Parameter: RUN_TIMEOUT, default 4095, maximum cycles spent in RUN waiting for ec_i before a timeout fault.
REQ-002 clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  reset; synchronous, active-high.
REQ-004 cmd_valid_i  input  1  host requests one program-and-run sequence.
REQ-005 cmd_ready_o  output  1  high only in IDLE; a command is accepted on a cycle with cmd_valid_i & cmd_ready_o.
REQ-006 plr_i, ulr_i, llr_i, ccr_i  input  8 each  preload, upper limit, lower limit and cycle count; captured on accept.
REQ-007 ncs_o, nwr_o, nrd_o  output  1 each  active-low chip-select, write strobe and read strobe to the counter.
REQ-008 a1_o, a0_o  output  1 each  register address: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
REQ-009 dout_o  output  8  write data; dout_oe_o  output  1  high while the sequencer drives the data bus.
REQ-010 din_i  input  8  readback data from the counter bus.
REQ-011 start_o  output  1  start pulse to the counter.
REQ-012 ec_i, err_i  input  1 each  end-of-count and error status from the counter.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 done_o  output  1  one-cycle completion pulse; fault_o  output  2  completion code, valid while done_o is high.

Function
REQ-015 FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_WAIT, RD_CHECK, ERR_CHK, START, RUN, DONE.
REQ-016 IDLE: ncs_o=1, nwr_o=1, nrd_o=1, dout_oe_o=0, start_o=0. On accept, latch all four fields, set the address index to 00 and go to WR_SETUP.
REQ-017 If ccr_i==0 at accept, go directly to DONE with fault_o=1 and issue no bus cycles.
REQ-018 WR_SETUP, 1 cycle: ncs_o=0, address and dout_o=latched field, dout_oe_o=1, nwr_o=1.
REQ-019 WR_STROBE, 1 cycle: same as WR_SETUP with nwr_o=0.
REQ-020 WR_HOLD, 1 cycle: nwr_o=1. Address and data are unchanged across all three cycles.
REQ-021 After WR_HOLD, go to RD_WAIT if readback is enabled, else to the next address. After address 11, go to ERR_CHK.
REQ-022 Write order is fixed: PLR, ULR, LLR, CCR. Without readback the four writes take exactly 12 cycles.
REQ-023 ERR_CHK, 1 cycle, ncs_o=0: if err_i=1 go to DONE with fault_o=1, else go to START.
REQ-024 START: start_o=1 for exactly one cycle. start_o is 0 in every other state.
REQ-025 RUN: ncs_o=0 and a timeout counter increments each cycle. ec_i=1 goes to DONE with fault_o=0.
REQ-026 In RUN, the counter reaching RUN_TIMEOUT without ec_i goes to DONE with fault_o=2. If ec_i and the timeout occur in the same cycle, ec_i wins.
REQ-027 DONE, 1 cycle: done_o=1, ncs_o=1, then return to IDLE. cmd_valid_i held high re-arms on the next IDLE cycle.
REQ-028 ncs_o stays 0 continuously from the first WR_SETUP through the end of RUN; the counter discards state whenever chip-select deasserts.
REQ-029 nwr_o and nrd_o are never 0 in the same cycle.

Reset
REQ-030 reset_i=1 at any clock edge, including mid-sequence, forces IDLE on that edge.
REQ-031 Reset values: ncs_o=1, nwr_o=1, nrd_o=1, dout_oe_o=0, start_o=0, done_o=0, fault_o=0, busy_o=0, cmd_ready_o=1, dout_o=0, address=00.
REQ-032 All latched fields and the timeout counter clear to 0 on reset; no done_o pulse is produced for an aborted sequence.

Configuration
REQ-033 Macro UDC_SEQ_READBACK_EN: when defined, each write is followed by RD_WAIT then RD_CHECK.
REQ-034 In RD_WAIT and RD_CHECK: nrd_o=0, nwr_o=1, dout_oe_o=0, address unchanged.
REQ-035 In RD_CHECK, din_i is compared with the written value; a mismatch goes to DONE with fault_o=3, a match proceeds per REQ-021. Programming then takes 20 cycles.
REQ-036 When UDC_SEQ_READBACK_EN is undefined, RD_WAIT and RD_CHECK do not exist, nrd_o is constant 1, and fault code 3 never occurs.

Verification
REQ-037 Reset, then accept plr=10, ulr=20, llr=5, ccr=2 -> four writes in order 00/01/10/11 with data 10/20/5/2, a 1-cycle nwr_o low each, then start_o high for 1 cycle.
REQ-038 Continuing REQ-037, drive ec_i=1 after 50 cycles in RUN -> done_o pulses once with fault_o=0, ncs_o=1 and cmd_ready_o=1 on the following cycle.
REQ-039 Accept with ccr=0 -> no nwr_o activity, and done_o with fault_o=1 within 2 cycles of accept.
REQ-040 err_i=1 during ERR_CHK (plr=30, ulr=20) -> start_o never asserts; done_o with fault_o=1.
REQ-041 RUN_TIMEOUT=15 and ec_i held 0 -> done_o with fault_o=2 exactly 15 cycles after the START cycle. Separately, assert reset_i during WR_STROBE of ULR -> IDLE and ncs_o=1 next cycle, with no done_o.
REQ-042 With UDC_SEQ_READBACK_EN defined, din_i returns 0x00 for the ULR readback -> done_o with fault_o=3 and no start_o.
